// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared constants, helpers and types for the pipelined adder/subtractor
// Purpose : mode encodings, chunk-width helper and the per-beat control struct.
// Ports   : none (package).
package pipelined_add_sub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Bits handled by each pipeline stage.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // Control half of an input stream beat.
   typedef struct packed {
      logic valid;
      logic sub;
      logic carry_in;
   } beat_ctrl_t;

endpackage

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - valid/ready operand and result streams of the adder/subtractor
// Purpose : bundles the input beat, result beat and both handshakes.
// Ports   : master = upstream/downstream side (drives operands, out_ready);
//           slave  = the adder (drives in_ready and the result).
interface pipelined_add_sub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
endinterface

// File: rtl/pipelined_add_sub_stage.sv
// rtl/pipelined_add_sub_stage.sv - one C-bit chunk of the pipelined ripple-carry adder
// Purpose : adds one operand chunk plus incoming carry and registers sum, carry and valid.
// Ports   : clock, reset (async, active-high), enable (pipeline advance),
//           valid_in/valid_out, a/b chunk operands, carry_in/carry_out, sum chunk.
module pipelined_add_sub_stage #(
   parameter int C = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         valid_in,
   input  logic [C-1:0] a,
   input  logic [C-1:0] b,
   input  logic         carry_in,
   output logic         valid_out,
   output logic [C-1:0] sum,
   output logic         carry_out
);
   logic [C:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, carry_in};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_out <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else if (enable) begin
         valid_out <= valid_in;
         sum       <= total[C-1:0];
         carry_out <= total[C];
      end
   end
endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready streams
// Purpose : splits operands into STAGES chunks, one chunk added per stage with the carry
//           registered in between; flags carry-out and signed overflow.
// Ports   : clock, reset (async, active-high), bus (slave modport: in_valid/in_ready,
//           a, b, carry_in, sub, out_valid/out_ready, sum, carry_out, overflow).
// Config  : ADDER_SATURATE_EN - clamp sum to the signed range when overflow is flagged.
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic                clock,
   input logic                reset,
   pipelined_add_sub_if.slave bus
);
   localparam int C = chunk_width(WIDTH, STAGES);

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
   end

   logic             advance;
   beat_ctrl_t       ctrl;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [STAGES:0]  valid_chain;
   logic [STAGES:0]  carry_chain;
   logic [C-1:0]     stage_a   [STAGES];
   logic [C-1:0]     stage_b   [STAGES];
   logic [C-1:0]     stage_sum [STAGES];
   logic [WIDTH-1:0] raw_sum;
   logic             top_a_msb;
   logic             top_b_msb;
   logic             ovf;

   // Whole pipeline moves as one; it only freezes while a finished result waits.
   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   assign ctrl  = '{valid: bus.in_valid, sub: bus.sub, carry_in: bus.carry_in};
   // Subtraction is a + ~b + ~borrow, so the mode is folded in before the first stage.
   assign b_eff = (ctrl.sub == MODE_SUB) ? ~bus.b : bus.b;
   assign c0    = (ctrl.sub == MODE_SUB) ? ~ctrl.carry_in : ctrl.carry_in;

   assign valid_chain[0] = ctrl.valid;
   assign carry_chain[0] = c0;

   for (genvar k = 0; k < STAGES; k++) begin : g_chunk
      // Chunk k reaches its stage k cycles after acceptance, in step with the carry.
      if (k == 0) begin : g_first
         assign stage_a[k] = bus.a[C-1:0];
         assign stage_b[k] = b_eff[C-1:0];
      end else begin : g_skew
         logic [C-1:0] a_sk [k];
         logic [C-1:0] b_sk [k];
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int d = 0; d < k; d++) begin
                  a_sk[d] <= '0;
                  b_sk[d] <= '0;
               end
            end else if (advance) begin
               a_sk[0] <= bus.a[k*C +: C];
               b_sk[0] <= b_eff[k*C +: C];
               for (int d = 1; d < k; d++) begin
                  a_sk[d] <= a_sk[d-1];
                  b_sk[d] <= b_sk[d-1];
               end
            end
         end
         assign stage_a[k] = a_sk[k-1];
         assign stage_b[k] = b_sk[k-1];
      end

      pipelined_add_sub_stage #(.C(C)) u_stage (
         .clock     (clock),
         .reset     (reset),
         .enable    (advance),
         .valid_in  (valid_chain[k]),
         .a         (stage_a[k]),
         .b         (stage_b[k]),
         .carry_in  (carry_chain[k]),
         .valid_out (valid_chain[k+1]),
         .sum       (stage_sum[k]),
         .carry_out (carry_chain[k+1])
      );

      // Lower result chunks finish early and wait until the top chunk is done.
      if (k == STAGES - 1) begin : g_last
         assign raw_sum[k*C +: C] = stage_sum[k];
      end else begin : g_deskew
         localparam int DEPTH = STAGES - 1 - k;
         logic [C-1:0] s_dk [DEPTH];
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int d = 0; d < DEPTH; d++) s_dk[d] <= '0;
            end else if (advance) begin
               s_dk[0] <= stage_sum[k];
               for (int d = 1; d < DEPTH; d++) s_dk[d] <= s_dk[d-1];
            end
         end
         assign raw_sum[k*C +: C] = s_dk[DEPTH-1];
      end
   end

   // Operand sign bits of the top stage, kept so the carry into the MSB can be rebuilt.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         top_a_msb <= 1'b0;
         top_b_msb <= 1'b0;
      end else if (advance) begin
         top_a_msb <= stage_a[STAGES-1][C-1];
         top_b_msb <= stage_b[STAGES-1][C-1];
      end
   end

   // carry into MSB = a ^ b ^ sum at that bit; overflow = that XOR carry out of MSB.
   assign ovf = carry_chain[STAGES] ^ top_a_msb ^ top_b_msb ^ raw_sum[WIDTH-1];

   assign bus.out_valid = valid_chain[STAGES];
   assign bus.carry_out = carry_chain[STAGES];
   assign bus.overflow  = ovf;

`ifdef ADDER_SATURATE_EN
   localparam logic [WIDTH-1:0] SAT_MAX = '1 >> 1;
   localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   // A wrapped result with the sign bit set came from a positive overflow.
   assign bus.sum = !ovf ? raw_sum : (raw_sum[WIDTH-1] ? SAT_MAX : SAT_MIN);
`else
   assign bus.sum = raw_sum;
`endif
endmodule
